// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and access-size helper for the LSU
package lsu_pkg;

    localparam logic [2:0] LSU_B   = 3'b000;
    localparam logic [2:0] LSU_H   = 3'b001;
    localparam logic [2:0] LSU_W   = 3'b010;
    localparam logic [2:0] LSU_D   = 3'b011;
    localparam logic [2:0] LSU_BU  = 3'b100;
    localparam logic [2:0] LSU_HU  = 3'b101;
    localparam logic [2:0] LSU_WU  = 3'b110;
    localparam logic [2:0] LSU_BAD = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R
    } lsu_state_t;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        return 4'(1 << funct3[1:0]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and extraction/extension for loads
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  off,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN/8-1:0]          be,
    output logic [XLEN-1:0]            wdata_lane,
    output logic [XLEN-1:0]            rdata_ext
);
    localparam int NB = XLEN / 8;

    logic [3:0]      size;
    logic [XLEN-1:0] wmasked;
    logic [XLEN-1:0] rshift;
    logic            sign_src;
    logic            sign;

    assign size = size_of(funct3);

    always_comb begin
        be      = '0;
        wmasked = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(size)) begin
                be[i]            = 1'b1;
                wmasked[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        be         = be << off;
        wdata_lane = wmasked << {off, 3'b000};
    end

    always_comb begin
        rshift = rdata >> {off, 3'b000};
        case (funct3)
            LSU_B, LSU_BU:  sign_src = rshift[7];
            LSU_H, LSU_HU:  sign_src = rshift[15];
            LSU_W, LSU_WU:  sign_src = rshift[31];
            default:        sign_src = rshift[XLEN-1];
        endcase
        // Unsigned forms (funct3[2]) fill with zero instead of the sign bit.
        sign = sign_src & ~funct3[2];
        rdata_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = (i < 8 * int'(size)) ? rshift[i] : sign;
        end
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request/grant/response memory handshake with core stall
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_valid,
    input  logic                lsu_we,
    input  logic [2:0]          lsu_funct3,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic                lsu_done,
    output logic                lsu_misaligned,
    output logic                lsu_stall,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t       state;
    logic [2:0]       r_funct3;
    logic [OFF_W-1:0] r_off;

    logic [OFF_W-1:0] off_in;
    logic [3:0]       size_in;
    logic             misal;
    logic             illegal;
    logic             accept;

    logic [2:0]       a_funct3;
    logic [OFF_W-1:0] a_off;
    logic [NB-1:0]    a_be;
    logic [XLEN-1:0]  a_wdata;
    logic [XLEN-1:0]  a_rdata;

    assign off_in  = lsu_addr[OFF_W-1:0];
    assign size_in = size_of(lsu_funct3);
    assign misal   = (off_in & OFF_W'(size_in - 4'd1)) != '0;
    assign illegal = (lsu_funct3 == LSU_BAD)
                   || ((XLEN == 32) && ((lsu_funct3 == LSU_D) || (lsu_funct3 == LSU_WU)))
                   || (lsu_we && lsu_funct3[2]);
    // The done cycle still shows lsu_valid high; it must not start a new access.
    assign accept    = (state == IDLE) && lsu_valid && !lsu_done;
    assign lsu_stall = lsu_valid && !lsu_done;

    // Steering uses the live request while idle, the latched one while a load is pending.
    assign a_funct3 = (state == IDLE) ? lsu_funct3 : r_funct3;
    assign a_off    = (state == IDLE) ? off_in : r_off;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (a_funct3),
        .off        (a_off),
        .wdata      (lsu_wdata),
        .rdata      (mem_rdata),
        .be         (a_be),
        .wdata_lane (a_wdata),
        .rdata_ext  (a_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            r_funct3       <= '0;
            r_off          <= '0;
            lsu_rdata      <= '0;
            lsu_done       <= 1'b0;
            lsu_misaligned <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_be         <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            lsu_done       <= 1'b0;
            lsu_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_funct3 <= lsu_funct3;
                        r_off    <= off_in;
                        if (misal || illegal) begin
                            lsu_done       <= 1'b1;
                            lsu_misaligned <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_we;
                            mem_be    <= a_be;
                            mem_addr  <= {lsu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                            mem_wdata <= a_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            lsu_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        lsu_rdata <= a_rdata;
                        lsu_done  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - checks 32- and 64-bit lsu instances against an arithmetic reference model
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, v32, v64, we, gnt, rvalid, sel;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata, rdata_in;

    logic [31:0] rd32, ma32, mwd32;
    logic        done32, mis32, stall32, req32, mwe32;
    logic [3:0]  be32;
    logic [63:0] rd64, mwd64;
    logic [31:0] ma64;
    logic        done64, mis64, stall64, req64, mwe64;
    logic [7:0]  be64;

    logic [63:0] o_rd, o_mwd;
    logic [31:0] o_ma;
    logic [7:0]  o_be;
    logic        o_done, o_mis, o_stall, o_req, o_mwe;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] last_rd [2];

    lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .lsu_valid(v32), .lsu_we(we), .lsu_funct3(f3),
        .lsu_addr(addr), .lsu_wdata(wdata[31:0]), .lsu_rdata(rd32), .lsu_done(done32),
        .lsu_misaligned(mis32), .lsu_stall(stall32), .mem_req(req32), .mem_gnt(gnt),
        .mem_we(mwe32), .mem_be(be32), .mem_addr(ma32), .mem_wdata(mwd32),
        .mem_rvalid(rvalid), .mem_rdata(rdata_in[31:0])
    );

    lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .lsu_valid(v64), .lsu_we(we), .lsu_funct3(f3),
        .lsu_addr(addr), .lsu_wdata(wdata), .lsu_rdata(rd64), .lsu_done(done64),
        .lsu_misaligned(mis64), .lsu_stall(stall64), .mem_req(req64), .mem_gnt(gnt),
        .mem_we(mwe64), .mem_be(be64), .mem_addr(ma64), .mem_wdata(mwd64),
        .mem_rvalid(rvalid), .mem_rdata(rdata_in)
    );

    always_comb begin
        o_rd    = sel ? rd64    : {32'b0, rd32};
        o_mwd   = sel ? mwd64   : {32'b0, mwd32};
        o_ma    = sel ? ma64    : ma32;
        o_be    = sel ? be64    : {4'b0, be32};
        o_done  = sel ? done64  : done32;
        o_mis   = sel ? mis64   : mis32;
        o_stall = sel ? stall64 : stall32;
        o_req   = sel ? req64   : req32;
        o_mwe   = sel ? mwe64   : mwe32;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdata"}, o_rd, 64'd0);
        chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
        chk({tag, "_mis"}, {63'd0, o_mis}, 64'd0);
        chk({tag, "_req"}, {63'd0, o_req}, 64'd0);
        chk({tag, "_we"}, {63'd0, o_mwe}, 64'd0);
        chk({tag, "_be"}, {56'd0, o_be}, 64'd0);
        chk({tag, "_addr"}, {32'd0, o_ma}, 64'd0);
        chk({tag, "_wdata"}, o_mwd, 64'd0);
    endtask

    // One transaction; expected values come from byte-level arithmetic on the access rules.
    task automatic txn(input bit x64, input bit w, input logic [2:0] fn, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] word, input int gd, input int rdl);
        int nb, size, off;
        bit fault;
        logic [127:0] v;
        logic [63:0] exp_be, exp_wd, exp_rd;
        logic [31:0] exp_ma;
        nb     = x64 ? 8 : 4;
        size   = 1 << fn[1:0];
        off    = int'(a % 32'(nb));
        fault  = (off % size != 0) || (fn == 3'b111) || (!x64 && (fn == 3'b011 || fn == 3'b110))
               || (w && fn[2]);
        exp_ma = a - 32'(off);
        exp_be = ((64'd1 << size) - 64'd1) << off;
        v      = {64'd0, wd} % (128'd1 << (8 * size));
        exp_wd = 64'(v << (8 * off));
        v      = ({64'd0, word} >> (8 * off)) % (128'd1 << (8 * size));
        if (!fn[2] && v >= (128'd1 << (8 * size - 1)))
            v = v - (128'd1 << (8 * size));
        exp_rd = 64'(v % (128'd1 << (8 * nb)));

        sel = x64; we = w; f3 = fn; addr = a; wdata = wd;
        v32 = !x64; v64 = x64;
        tick();
        if (fault) begin
            chk("flt_done", {63'd0, o_done}, 64'd1);
            chk("flt_mis", {63'd0, o_mis}, 64'd1);
            chk("flt_req", {63'd0, o_req}, 64'd0);
            chk("flt_rdata", o_rd, last_rd[x64]);
        end else begin
            chk("req", {63'd0, o_req}, 64'd1);
            chk("addr", {32'd0, o_ma}, {32'd0, exp_ma});
            chk("be", {56'd0, o_be}, exp_be);
            chk("we", {63'd0, o_mwe}, {63'd0, w});
            if (w) chk("wdata", o_mwd, exp_wd);
            for (int i = 0; i < gd; i++) begin
                chk("stall_req", {63'd0, o_stall}, 64'd1);
                tick();
                chk("req_held", {31'd0, o_req, o_ma}, {31'd0, 1'b1, exp_ma});
                chk("be_held", {56'd0, o_be}, exp_be);
            end
            gnt = 1'b1;
            tick();
            gnt = 1'b0;
            if (w) begin
                chk("st_done", {63'd0, o_done}, 64'd1);
                chk("st_mis", {63'd0, o_mis}, 64'd0);
            end else begin
                chk("ld_req_drop", {62'd0, o_req, o_done}, 64'd0);
                for (int i = 0; i < rdl; i++) begin
                    chk("ld_stall", {63'd0, o_stall}, 64'd1);
                    tick();
                    chk("ld_wait", {63'd0, o_done}, 64'd0);
                end
                rvalid = 1'b1; rdata_in = word;
                tick();
                rvalid = 1'b0;
                chk("ld_done", {63'd0, o_done}, 64'd1);
                chk("ld_mis", {63'd0, o_mis}, 64'd0);
                chk("ld_rdata", o_rd, exp_rd);
                last_rd[x64] = exp_rd;
            end
        end
        chk("done_stall", {63'd0, o_stall}, 64'd0);
        // lsu_valid stays high across this edge: it must not start another access.
        tick();
        chk("done_pulse", {62'd0, o_done, o_mis}, 64'd0);
        chk("no_reaccept", {63'd0, o_req}, 64'd0);
        v32 = 1'b0; v64 = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; v32 = 1'b0; v64 = 1'b0; we = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        sel = 1'b0; f3 = '0; addr = '0; wdata = '0; rdata_in = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        tick(); tick();
        chk_reset_vals("rst32");
        sel = 1'b1;
        chk_reset_vals("rst64");
        rst_n = 1'b1;
        tick();

        txn(0, 1, 3'b000, 32'h1003, 64'hAABBCCDD, 64'd0, 0, 0);
        txn(0, 0, 3'b000, 32'h2001, 64'd0, 64'h12348056, 0, 0);
        chk("tp_lb", o_rd, 64'hFFFFFF80);
        txn(0, 0, 3'b100, 32'h2001, 64'd0, 64'h12348056, 0, 0);
        chk("tp_lbu", o_rd, 64'h00000080);
        txn(0, 0, 3'b001, 32'h2002, 64'd0, 64'h9ABC0000, 3, 1);
        chk("tp_lh", o_rd, 64'hFFFF9ABC);
        txn(0, 0, 3'b010, 32'h3002, 64'd0, 64'd0, 0, 0);
        chk("tp_lw_keep", o_rd, 64'hFFFF9ABC);
        txn(1, 0, 3'b110, 32'h4004, 64'd0, 64'h80000001_00000000, 0, 0);
        chk("tp_lwu", o_rd, 64'h0000000080000001);
        txn(1, 0, 3'b011, 32'h4004, 64'd0, 64'd0, 0, 0);
        txn(1, 1, 3'b011, 32'h5000, 64'h0123456789ABCDEF, 64'd0, 1, 0);

        // Stray rvalid while idle must not touch lsu_rdata.
        sel = 1'b0; rvalid = 1'b1; rdata_in = 64'h5555_5555;
        tick();
        rvalid = 1'b0;
        chk("stray_rvalid", {62'd0, o_done, o_mis}, 64'd0);
        chk("stray_rdata", o_rd, last_rd[0]);

        for (int n = 0; n < 80; n++) begin
            bit          x;
            logic [31:0] a;
            x = 1'($urandom_range(0, 1));
            a = ($urandom & 32'h0000FFF0) | 32'($urandom_range(0, 7) & (x ? 7 : 3));
            txn(x, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a load waits for data; the late rvalid must be ignored.
        sel = 1'b0; we = 1'b0; f3 = 3'b010; addr = 32'h100; v32 = 1'b1;
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        rst_n = 1'b0; v32 = 1'b0;
        tick();
        chk_reset_vals("midrst");
        rst_n = 1'b1; rvalid = 1'b1; rdata_in = 64'hDEADBEEF;
        tick();
        rvalid = 1'b0;
        chk_reset_vals("late_rv");
        tick();
        chk("late_rv_nodone", {63'd0, o_done}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit sitting between the core's ALU/register-file stage and the data-memory port. Accepts one load or store per transaction and drives a request/grant/response memory handshake with byte enables. Steers byte lanes, sign- or zero-extends load data for B/H/W/D and their unsigned forms, and flags misaligned accesses. Stalls the core for as many cycles as memory needs, replacing the fixed single-cycle load/store path.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- lsu_valid  in  1  core requests access; held high until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
- lsu_addr  in  ADDR_W  byte address (ALU result)
- lsu_wdata  in  XLEN  store data, right-aligned (rs2)
- lsu_rdata  out  XLEN  extended load result
- lsu_done  out  1  one-cycle completion pulse
- lsu_misaligned  out  1  one-cycle fault pulse, coincident with lsu_done
- lsu_stall  out  1  core must hold PC and suppress regfile write
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepted request this cycle
- mem_we  out  1  write enable
- mem_be  out  XLEN/8  byte enables
- mem_addr  out  ADDR_W  word-aligned address (low log2(XLEN/8) bits zero)
- mem_wdata  out  XLEN  lane-steered store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  raw word from memory

## Operation
- States: IDLE, REQ, WAIT_R.
- OFF = lsu_addr[log2(XLEN/8)-1:0]; SIZE = 1/2/4/8 bytes from funct3[1:0].
- Accept in IDLE when lsu_valid && !lsu_done: latch we, funct3, addr, wdata.
- Misaligned (OFF mod SIZE != 0) or illegal funct3 (011/110/111 for XLEN=32, 111 for 64, 1xx with we=1): no memory request; next cycle lsu_done=1, lsu_misaligned=1, lsu_rdata unchanged; stay IDLE.
- Otherwise go REQ: mem_req=1, mem_addr = addr with low bits cleared, mem_we=we, mem_be = ((1<<SIZE)-1) << OFF, mem_wdata = wdata << 8*OFF (bytes above SIZE zeroed before shift). Held stable until mem_gnt.
- REQ + gnt, store: lsu_done next cycle, -> IDLE.
- REQ + gnt, load: -> WAIT_R. On mem_rvalid: lsu_rdata <= extend(mem_rdata >> 8*OFF, SIZE, funct3[2]), lsu_done next cycle, -> IDLE.
- funct3[2]=0 sign-extends from bit 8*SIZE-1; funct3[2]=1 zero-extends.
- lsu_stall = lsu_valid && !lsu_done (combinational).
- mem_rvalid outside WAIT_R ignored.

## Timing
- Reset values: state IDLE; lsu_rdata 0; lsu_done 0; lsu_misaligned 0; mem_req 0; mem_we 0; mem_be 0; mem_addr 0; mem_wdata 0.
- Minimum latency (gnt same cycle as req): store 2 cycles accept->done; load 3 cycles with rvalid the cycle after gnt. Fault: 1 cycle.
- Memory must not assert mem_rvalid in the same cycle as mem_gnt.
- mem_* outputs registered; no combinational path from mem_gnt/mem_rvalid to mem_*.
- lsu_done high exactly one cycle; lsu_valid seen high in that cycle is not a new request.
- rst_n low mid-transaction: next edge forces reset values; a late mem_rvalid is ignored; no lsu_done pulse.

## Structure
- Package lsu_pkg: funct3 constants (LSU_B..LSU_WU), state enum lsu_state_t, function size_of(funct3).
- Sub-module lsu_align: combinational lane steering (be, wdata shift) and load extraction/extension, parametrised by XLEN; FSM and registers stay in lsu.

## Test plan
- XLEN=32, store SB addr 0x1003 wdata 0xAABBCCDD, gnt immediate -> mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xDD000000, lsu_done 2 cycles after accept.
- Load LB addr 0x2001, mem_rdata 0x12348056 -> lsu_rdata 0xFFFFFF80; repeat as LBU -> 0x00000080.
- Load LH addr 0x2002, mem_rdata 0x9ABC0000, gnt delayed 3 cycles, rvalid 2 cycles later -> mem_req held constant throughout, lsu_rdata 0xFFFF9ABC, lsu_stall high until lsu_done.
- LW addr 0x3002 -> no mem_req, lsu_done+lsu_misaligned pulse next cycle, lsu_rdata unchanged.
- XLEN=64, LWU addr 0x4004, mem_rdata 0x80000001_00000000 -> lsu_rdata 0x0000000080000001; LD addr 0x4004 -> misaligned.
- rst_n low in WAIT_R, rvalid asserted next cycle -> all outputs at reset values, no lsu_done.
